// File: rtl/asteroids_rom_loader_if.sv
// Download-side and ROM-side signal bundle for asteroids_rom_loader.
// The loader uses the slave view; the HPS/bench side uses master.
interface asteroids_rom_loader_if;
  logic        dn_download;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        prog_we;
  logic [12:0] prog_addr;
  logic        vrom_we;
  logic [10:0] vrom_addr;
  logic [7:0]  wdata;
  logic        game_reset_l;
  logic        load_ok;
  logic        load_err;
  logic [15:0] byte_cnt;

  modport slave (
    input  dn_download, dn_wr, dn_addr, dn_data,
    output prog_we, prog_addr, vrom_we, vrom_addr, wdata,
    output game_reset_l, load_ok, load_err, byte_cnt
  );

  modport master (
    output dn_download, dn_wr, dn_addr, dn_data,
    input  prog_we, prog_addr, vrom_we, vrom_addr, wdata,
    input  game_reset_l, load_ok, load_err, byte_cnt
  );
endinterface

// File: rtl/asteroids_rom_loader.sv
// ROM download sequencer: splits the ioctl byte stream into program/vector ROM writes and
// holds the core in reset until a full image is loaded. Define ROM_CHECKSUM_EN to add a sum check.
module asteroids_rom_loader #(
  parameter int          PROG_BYTES = 6144,
  parameter int          VROM_BYTES = 2048,
  parameter logic [15:0] EXPECT_SUM = 16'h0000
) (
  input  logic clk_25,
  input  logic RESET_L,
  asteroids_rom_loader_if.slave bus
);

  // state | meaning
  // IDLE  | no image yet, core held in reset
  // LOAD  | download window open, bytes accepted
  // CHECK | one cycle to judge count/oob/sum
  // READY | image accepted, core released
  // ERROR | image rejected, core held in reset
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, READY, ERROR} state_t;

  localparam logic [16:0] PROG_END  = 17'(PROG_BYTES);
  localparam logic [16:0] IMG_END   = 17'(PROG_BYTES + VROM_BYTES);
  localparam logic [15:0] VROM_BASE = 16'(PROG_BYTES);

  state_t      state, state_nx;
  logic        dl_q;
  logic        oob;
  logic        dl_rise, dl_fall, start;
  logic        accept_wr, hit_prog, hit_vrom, hit_any;
  logic        image_ok;
  logic [10:0] vrom_off;

  logic        prog_we_q, vrom_we_q;
  logic [12:0] prog_addr_q;
  logic [10:0] vrom_addr_q;
  logic [7:0]  wdata_q;
  logic        game_reset_l_q, load_ok_q, load_err_q;
  logic [15:0] cnt_q;

  assign dl_rise   = bus.dn_download & ~dl_q;
  assign dl_fall   = ~bus.dn_download & dl_q;
  assign hit_prog  = {1'b0, bus.dn_addr} < PROG_END;
  assign hit_vrom  = !hit_prog && ({1'b0, bus.dn_addr} < IMG_END);
  assign hit_any   = hit_prog || hit_vrom;
  assign accept_wr = (state == LOAD) && bus.dn_wr;
  assign start     = dl_rise && ((state == IDLE) || (state == READY) || (state == ERROR));
  // Only the low 11 bits survive into the vector ROM, so the subtract can stay narrow.
  assign vrom_off  = bus.dn_addr[10:0] - VROM_BASE[10:0];

`ifdef ROM_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      sum_q <= 16'h0000;
    end else if (start) begin
      sum_q <= 16'h0000;
    end else if (accept_wr && hit_any) begin
      sum_q <= sum_q + {8'h00, bus.dn_data};
    end
  end

  assign image_ok = ({1'b0, cnt_q} == IMG_END) && !oob && (sum_q == EXPECT_SUM);
`else
  logic unused_expect;
  assign unused_expect = ^EXPECT_SUM;
  assign image_ok = ({1'b0, cnt_q} == IMG_END) && !oob;
`endif

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         if (dl_rise) state_nx = LOAD;
      LOAD:         if (dl_fall) state_nx = CHECK;
      CHECK:        state_nx = image_ok ? READY : ERROR;
      READY, ERROR: if (dl_rise) state_nx = LOAD;
      default:      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      dl_q           <= 1'b0;
      oob            <= 1'b0;
      prog_we_q      <= 1'b0;
      vrom_we_q      <= 1'b0;
      prog_addr_q    <= '0;
      vrom_addr_q    <= '0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      game_reset_l_q <= 1'b0;
      load_ok_q      <= 1'b0;
      load_err_q     <= 1'b0;
    end else begin
      dl_q      <= bus.dn_download;
      prog_we_q <= accept_wr && hit_prog;
      vrom_we_q <= accept_wr && hit_vrom;
      if (accept_wr && hit_prog) prog_addr_q <= bus.dn_addr[12:0];
      if (accept_wr && hit_vrom) vrom_addr_q <= vrom_off;
      if (accept_wr && hit_any)  wdata_q     <= bus.dn_data;
      if (start) begin
        cnt_q <= '0;
        oob   <= 1'b0;
      end else if (accept_wr) begin
        if (!hit_any)                oob   <= 1'b1;
        else if (cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
      end
      // Status follows the next state so it lines up with the state register.
      game_reset_l_q <= (state_nx == READY);
      load_ok_q      <= (state_nx == READY);
      load_err_q     <= (state_nx == ERROR);
    end
  end

  assign bus.prog_we      = prog_we_q;
  assign bus.prog_addr    = prog_addr_q;
  assign bus.vrom_we      = vrom_we_q;
  assign bus.vrom_addr    = vrom_addr_q;
  assign bus.wdata        = wdata_q;
  assign bus.game_reset_l = game_reset_l_q;
  assign bus.load_ok      = load_ok_q;
  assign bus.load_err     = load_err_q;
  assign bus.byte_cnt     = cnt_q;

endmodule

// File: tb/tb_asteroids_rom_loader.sv
// Bench for asteroids_rom_loader: drives download images and compares against a byte-level model.
// Build with ROM_CHECKSUM_EN defined to also exercise the checksum path.
module tb_asteroids_rom_loader;
  localparam int PROG = 6144;
  localparam int VROM = 2048;
  localparam int TOTAL = PROG + VROM;
`ifdef ROM_CHECKSUM_EN
  localparam logic [15:0] EXP_SUM = 16'hF000;
`else
  localparam logic [15:0] EXP_SUM = 16'h1234;
`endif

  logic clk_25 = 1'b0;
  logic RESET_L = 1'b0;
  always #20 clk_25 = ~clk_25;

  asteroids_rom_loader_if bus();

  asteroids_rom_loader #(
    .PROG_BYTES(PROG), .VROM_BYTES(VROM), .EXPECT_SUM(EXP_SUM)
  ) dut (
    .clk_25(clk_25), .RESET_L(RESET_L), .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  int n_prog = 0;
  int n_vrom = 0;
  always @(negedge clk_25) begin
    if (bus.prog_we === 1'b1) n_prog++;
    if (bus.vrom_we === 1'b1) n_vrom++;
  end

  bit          m_loading = 0;
  int          m_cnt = 0;
  logic [15:0] m_sum = '0;
  bit          m_oob = 0;
  int          m_np = 0, m_nv = 0;
  int          base_p = 0, base_v = 0;

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_prog_we"}, bus.prog_we, 0);
    chk({tag, "_vrom_we"}, bus.vrom_we, 0);
    chk({tag, "_prog_addr"}, bus.prog_addr, 0);
    chk({tag, "_vrom_addr"}, bus.vrom_addr, 0);
    chk({tag, "_wdata"}, bus.wdata, 0);
    chk({tag, "_game_reset_l"}, bus.game_reset_l, 0);
    chk({tag, "_load_ok"}, bus.load_ok, 0);
    chk({tag, "_load_err"}, bus.load_err, 0);
    chk({tag, "_byte_cnt"}, bus.byte_cnt, 0);
  endtask

  // Drive one byte at a negedge; the strobe must be visible at the next negedge.
  task automatic send_byte(input logic [15:0] addr, input logic [7:0] data, input bit last_fall);
    bit in_p, in_v;
    bus.dn_addr = addr;
    bus.dn_data = data;
    bus.dn_wr   = 1'b1;
    if (last_fall) bus.dn_download = 1'b0;
    @(posedge clk_25);
    in_p = m_loading && (int'(addr) < PROG);
    in_v = m_loading && (int'(addr) >= PROG) && (int'(addr) < TOTAL);
    if (in_p || in_v) begin
      if (m_cnt < 65535) m_cnt++;
      m_sum = m_sum + 16'(data);
      if (in_p) m_np++; else m_nv++;
    end else if (m_loading) begin
      m_oob = 1;
    end
    @(negedge clk_25);
    bus.dn_wr = 1'b0;
    chk("prog_we", bus.prog_we, in_p);
    chk("vrom_we", bus.vrom_we, in_v);
    if (in_p) chk("prog_addr", bus.prog_addr, addr % 8192);
    if (in_v) chk("vrom_addr", bus.vrom_addr, int'(addr) - PROG);
    if (in_p || in_v) chk("wdata", bus.wdata, data);
    chk("byte_cnt", bus.byte_cnt, m_cnt);
  endtask

  task automatic start_dl();
    bus.dn_download = 1'b1;
    @(negedge clk_25);
    m_loading = 1; m_cnt = 0; m_sum = '0; m_oob = 0; m_np = 0; m_nv = 0;
    base_p = n_prog; base_v = n_vrom;
    chk("start_byte_cnt", bus.byte_cnt, 0);
    chk("start_load_ok", bus.load_ok, 0);
    chk("start_load_err", bus.load_err, 0);
    chk("start_game_reset_l", bus.game_reset_l, 0);
  endtask

  task automatic end_dl(input bit fall_done);
    bit ok;
    if (!fall_done) begin
      bus.dn_download = 1'b0;
      @(negedge clk_25);
    end
    m_loading = 0;
    chk("check_game_reset_l", bus.game_reset_l, 0);
    chk("check_load_ok", bus.load_ok, 0);
    @(negedge clk_25);
    ok = (m_cnt == TOTAL) && !m_oob;
`ifdef ROM_CHECKSUM_EN
    ok = ok && (m_sum == EXP_SUM);
`endif
    chk("final_load_ok", bus.load_ok, ok);
    chk("final_load_err", bus.load_err, !ok);
    chk("final_game_reset_l", bus.game_reset_l, ok);
    chk("final_byte_cnt", bus.byte_cnt, m_cnt);
    chk("prog_pulses", n_prog - base_p, m_np);
    chk("vrom_pulses", n_vrom - base_v, m_nv);
  endtask

  initial begin
    bus.dn_download = 1'b0;
    bus.dn_wr = 1'b0;
    bus.dn_addr = '0;
    bus.dn_data = '0;
    repeat (3) @(negedge clk_25);
    reset_outputs_chk("rst");
    RESET_L = 1'b1;
    @(negedge clk_25);

    // dn_wr outside a download window must be ignored
    send_byte(16'h0010, 8'hAA, 0);

    // full sequential image, data = addr[7:0]
    start_dl();
    for (int i = 0; i < TOTAL; i++) send_byte(16'(i), 8'(i), 0);
    end_dl(0);

    // short image with random data and random idle gaps
    start_dl();
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk_25);
      send_byte(16'(i), 8'($urandom), 0);
    end
    end_dl(0);
    repeat (5) @(negedge clk_25);
    chk("err_hold_load_err", bus.load_err, 1);
    chk("err_hold_game_reset_l", bus.game_reset_l, 0);
    send_byte(16'h0020, 8'h55, 0);

    // full image plus one out-of-range byte at 0x2000
    start_dl();
    for (int i = 0; i < TOTAL; i++) send_byte(16'(i), 8'(i), 0);
    send_byte(16'h2000, 8'($urandom), 0);
    chk("oob_flag_model", m_oob, 1);
    end_dl(0);

`ifdef ROM_CHECKSUM_EN
    // one byte lowered so the expected sum is one above the image sum
    start_dl();
    for (int i = 0; i < TOTAL; i++) send_byte(16'(i), (i == 100) ? 8'(i - 1) : 8'(i), 0);
    end_dl(0);
`endif

    // reset mid-download, then a complete image whose last byte lands on the falling edge
    start_dl();
    for (int i = 0; i < 3000; i++) send_byte(16'(i), 8'($urandom), 0);
    RESET_L = 1'b0;
    bus.dn_download = 1'b0;
    #1;
    reset_outputs_chk("midrst");
    @(negedge clk_25);
    RESET_L = 1'b1;
    m_loading = 0; m_cnt = 0;
    @(negedge clk_25);
    reset_outputs_chk("idle_after_rst");

    start_dl();
    for (int i = 0; i < TOTAL; i++) send_byte(16'(i), 8'(i), i == TOTAL - 1);
    end_dl(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
